// File: rtl/io_port_responder.sv
// ============================================================================
// io_port_responder
//
// Device-side responder for the accumulator CPU's memory-mapped I/O window.
// It sits between the CPU memory bus and an external device that uses
// valid/ready handshakes.
//
//   Inbound  : single-entry holding register, filled by the device and
//              popped by a CPU load from IO_DATA_ADDR.
//   Outbound : OUT_DEPTH-entry FIFO, pushed by a CPU store to IO_DATA_ADDR
//              and drained by the device.
//   Status   : a CPU load from IO_STAT_ADDR returns
//              {4'b0, count[3:0], 3'b0, overflow, underflow,
//               out_empty, out_full, in_full}.
//              A CPU store to IO_STAT_ADDR is write-1-to-clear
//              (WrData[4] clears overflow, WrData[3] clears underflow).
//
// Ports
//   CLK          system clock, rising edge
//   Reset        asynchronous, active-high reset
//   Addr         CPU memory address
//   WrData       CPU store data
//   MemWrite     CPU store strobe
//   MemRead      CPU load strobe (ignored when MemWrite is also high)
//   RdData       registered read data
//   RdHit        registered, high when RdData answers an I/O address
//   ExtInData    device-to-CPU data
//   ExtInValid   device data valid
//   ExtInReady   responder can accept inbound data
//   ExtOutData   CPU-to-device data (FIFO head)
//   ExtOutValid  outbound FIFO non-empty
//   ExtOutReady  device accepts the head entry
//   Irq          (only with IO_IRQ_EN) registered in_full|overflow|underflow
//
// Optional feature: define IO_IRQ_EN to add the registered Irq output.
// ============================================================================
module io_port_responder #(
    parameter logic [15:0] IO_DATA_ADDR = 16'hfffe,
    parameter logic [15:0] IO_STAT_ADDR = 16'hfffc,
    parameter int unsigned OUT_DEPTH    = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] Addr,
    input  logic [15:0] WrData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [15:0] RdData,
    output logic        RdHit,
    input  logic [15:0] ExtInData,
    input  logic        ExtInValid,
    output logic        ExtInReady,
    output logic [15:0] ExtOutData,
    output logic        ExtOutValid,
`ifdef IO_IRQ_EN
    input  logic        ExtOutReady,
    output logic        Irq
`else
    input  logic        ExtOutReady
`endif
);

    localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CW = $clog2(OUT_DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(OUT_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          in_full;
    logic [15:0]   in_data;
    logic [15:0]   mem [OUT_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic rd_cycle;     // a load that is not overridden by a store
    logic rd_data_sel;
    logic rd_stat_sel;
    logic wr_data_sel;
    logic wr_stat_sel;

    always_comb begin
        rd_cycle    = MemRead && !MemWrite;
        rd_data_sel = rd_cycle && (Addr == IO_DATA_ADDR);
        rd_stat_sel = rd_cycle && (Addr == IO_STAT_ADDR);
        wr_data_sel = MemWrite && (Addr == IO_DATA_ADDR);
        wr_stat_sel = MemWrite && (Addr == IO_STAT_ADDR);
    end

    // ------------------------------------------------------------------
    // Handshakes and FIFO control
    // ------------------------------------------------------------------
    logic out_full;
    logic out_empty;
    logic in_accept;
    logic out_pop;
    logic out_push;
    logic set_overflow;
    logic set_underflow;

    always_comb begin
        out_full      = (count == FULL_COUNT);
        out_empty     = (count == '0);
        ExtInReady    = !in_full;
        ExtOutValid   = !out_empty;
        ExtOutData    = mem[rd_ptr];
        // A pop only happens while in_full, when ExtInReady is low, so an
        // accept can never coincide with a pop of held data.
        in_accept     = ExtInValid && !in_full;
        out_pop       = ExtOutValid && ExtOutReady;
        // A pop in the same cycle frees the slot the push needs.
        out_push      = wr_data_sel && (!out_full || out_pop);
        set_overflow  = wr_data_sel && out_full && !out_pop;
        set_underflow = rd_data_sel && !in_full;
    end

    logic [3:0]  count4;
    logic [15:0] status;

    always_comb begin
        count4 = 4'(count);
        status = {4'b0000, count4, 3'b000, overflow, underflow,
                  out_empty, out_full, in_full};
    end

    // ------------------------------------------------------------------
    // Inbound holding register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            in_full <= 1'b0;
            in_data <= '0;
        end else if (in_accept) begin
            in_full <= 1'b1;
            in_data <= ExtInData;
        end else if (rd_data_sel) begin
            in_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outbound FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (out_push) begin
                mem[wr_ptr] <= WrData;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (out_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (out_push && !out_pop) begin
                count <= count + 1'b1;
            end else if (out_pop && !out_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky error bits: set takes priority over write-1-to-clear
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (set_overflow) begin
                overflow <= 1'b1;
            end else if (wr_stat_sel && WrData[4]) begin
                overflow <= 1'b0;
            end
            if (set_underflow) begin
                underflow <= 1'b1;
            end else if (wr_stat_sel && WrData[3]) begin
                underflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered read port; non-I/O loads keep the previous RdData
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            RdData <= '0;
            RdHit  <= 1'b0;
        end else if (rd_data_sel) begin
            RdData <= in_full ? in_data : 16'h0000;
            RdHit  <= 1'b1;
        end else if (rd_stat_sel) begin
            RdData <= status;
            RdHit  <= 1'b1;
        end else begin
            RdHit  <= 1'b0;
        end
    end

`ifdef IO_IRQ_EN
    // ------------------------------------------------------------------
    // Interrupt: registered copy of the pending conditions
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Irq <= 1'b0;
        end else begin
            Irq <= in_full | overflow | underflow;
        end
    end
`endif

endmodule
